// File: rtl/frame_plot_scheduler_if.sv
// frame_plot_scheduler_if: renderer pixel buses, grant vector and the vga_adapter write port.
interface frame_plot_scheduler_if #(parameter int NUM_SRC = 3);
   logic [NUM_SRC-1:0]   req;
   logic [NUM_SRC-1:0]   src_valid;
   logic [NUM_SRC-1:0]   src_last;
   logic [8*NUM_SRC-1:0] src_x;
   logic [7*NUM_SRC-1:0] src_y;
   logic [3*NUM_SRC-1:0] src_colour;
   logic [NUM_SRC-1:0]   gnt;
   logic [7:0]           vga_x;
   logic [6:0]           vga_y;
   logic [2:0]           vga_colour;
   logic                 vga_plot;
   modport master (
      output req, src_valid, src_last, src_x, src_y, src_colour,
      input  gnt, vga_x, vga_y, vga_colour, vga_plot
   );
   modport slave (
      input  req, src_valid, src_last, src_x, src_y, src_colour,
      output gnt, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/frame_plot_scheduler.sv
// frame_plot_scheduler: per-frame round of fixed-priority grants sharing one vga_adapter write port.
// Optional per-grant watchdog enabled by RENDER_WATCHDOG_EN.
module frame_plot_scheduler #(
   parameter int NUM_SRC = 3,
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int TIMEOUT = 16384
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start,
   frame_plot_scheduler_if.slave bus,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 overrun,
   output logic [NUM_SRC-1:0]   timeout_flags
);
   typedef enum logic [1:0] {IDLE, SCAN, GRANT, DONE} state_t;
   state_t state;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] first;
   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_c;
   logic take;
   logic last;
   logic clip;
   logic wd_hit;
   assign first = pending & (~pending + NUM_SRC'(1));
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_c = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         sel_x |= bus.gnt[i] ? bus.src_x[8*i +: 8] : 8'd0;
         sel_y |= bus.gnt[i] ? bus.src_y[7*i +: 7] : 7'd0;
         sel_c |= bus.gnt[i] ? bus.src_colour[3*i +: 3] : 3'd0;
      end
   end
   assign take = |(bus.gnt & bus.src_valid);
   assign last = |(bus.gnt & bus.src_valid & bus.src_last);
   assign clip = sel_x >= 8'(H_RES) || sel_y >= 7'(V_RES);
`ifdef RENDER_WATCHDOG_EN
   logic [13:0] wd;
   // A src_last in the timeout cycle takes precedence over the forced release.
   assign wd_hit = state == GRANT && wd == 14'(TIMEOUT - 1) && !last;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd            <= '0;
         timeout_flags <= '0;
      end else begin
         wd <= state == GRANT ? wd + 14'd1 : 14'd0;
         if (wd_hit) timeout_flags <= timeout_flags | bus.gnt;
      end
   end
`else
   assign wd_hit        = 1'b0;
   assign timeout_flags = '0;
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         pending        <= '0;
         bus.gnt        <= '0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         bus.vga_plot <= 1'b0;
         frame_done   <= 1'b0;
         if (frame_start && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (frame_start) begin
               pending <= bus.req;
               busy    <= 1'b1;
               state   <= SCAN;
            end
            SCAN: begin
               bus.gnt <= first;
               state   <= |pending ? GRANT : DONE;
            end
            GRANT: begin
               if (take && !wd_hit && !clip) begin
                  bus.vga_x      <= sel_x;
                  bus.vga_y      <= sel_y;
                  bus.vga_colour <= sel_c;
                  bus.vga_plot   <= 1'b1;
               end
               if (last || wd_hit) begin
                  pending <= pending & ~bus.gnt;
                  bus.gnt <= '0;
                  state   <= SCAN;
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_frame_plot_scheduler.sv
// tb_frame_plot_scheduler: directed passes with a pixel scoreboard drained by a negedge monitor.
module tb_frame_plot_scheduler;
   localparam int N = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic frame_start = 1'b0;
   logic busy, frame_done, overrun;
   logic [N-1:0] timeout_flags;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic saw_g1 = 1'b0;
   logic saw_gnt = 1'b0;
   typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
   pix_t exp_q[$];
   pix_t exp_p;
   frame_plot_scheduler_if #(.NUM_SRC(N)) bus();
   frame_plot_scheduler #(.NUM_SRC(N), .H_RES(160), .V_RES(120), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start), .bus(bus),
      .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_flags(timeout_flags)
   );
   always #5 clk = ~clk;
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Scoreboard monitor: every plotted pixel must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_done) done_cnt++;
         if (|bus.gnt) saw_gnt = 1'b1;
         if (bus.gnt[1]) saw_g1 = 1'b1;
         if (bus.vga_plot) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pixel: unexpected plot x=%0d y=%0d c=%0d", bus.vga_x, bus.vga_y, bus.vga_colour);
            end else begin
               exp_p = exp_q.pop_front();
               check("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, exp_p);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start(logic [N-1:0] r);
      bus.req = r;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask
   task automatic pix(int i, int x, int y, int c, bit lst, bit plot);
      bus.src_valid[i] = 1'b1;
      bus.src_last[i] = lst;
      bus.src_x[8*i +: 8] = 8'(x);
      bus.src_y[7*i +: 7] = 7'(y);
      bus.src_colour[3*i +: 3] = 3'(c);
      if (plot) exp_q.push_back({8'(x), 7'(y), 3'(c)});
      tick();
      bus.src_valid[i] = 1'b0;
      bus.src_last[i] = 1'b0;
   endtask
   task automatic wait_gnt(logic [N-1:0] m, string name);
      int n = 0;
      while (bus.gnt !== m && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(bus.gnt), 32'(m));
   endtask
   task automatic wait_done(string name);
      int n = 0;
      while (frame_done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(frame_done), 1);
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
   initial begin
      int n;
      bus.req = '0;
      bus.src_valid = '0;
      bus.src_last = '0;
      bus.src_x = '0;
      bus.src_y = '0;
      bus.src_colour = '0;
      #1 reset = 1'b1;
      #2 check("reset_outs", {bus.gnt, bus.vga_plot, busy, frame_done, overrun, timeout_flags}, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      // Two renderers; renderer 1 holds valid without a request or grant.
      bus.src_valid[1] = 1'b1;
      bus.src_x[15:8] = 8'd50;
      bus.src_y[13:7] = 7'd50;
      bus.src_colour[5:3] = 3'd7;
      start(3'b101);
      check("busy_a", 32'(busy), 1);
      check("gnt_scan_a", 32'(bus.gnt), 0);
      tick();
      check("gnt0_a", 32'(bus.gnt), 32'b001);
      pix(0, 10, 20, 1, 0, 1);
      pix(0, 11, 21, 2, 0, 1);
      pix(0, 12, 22, 3, 1, 1);
      check("gnt_rel_a", 32'(bus.gnt), 0);
      wait_gnt(3'b100, "gnt2_a");
      pix(2, 100, 5, 4, 0, 1);
      pix(2, 101, 6, 5, 1, 1);
      bus.src_valid[1] = 1'b0;
      wait_done("done_a");
      repeat (3) tick();
      check("done_cnt_a", done_cnt, 1);
      check("no_gnt1_a", 32'(saw_g1), 0);
      check("queue_a", exp_q.size(), 0);
      // Last pixel on the boundary, then clipped pixels from the next renderer.
      done_cnt = 0;
      start(3'b011);
      wait_gnt(3'b001, "gnt0_b");
      pix(0, 159, 119, 6, 1, 1);
      wait_gnt(3'b010, "gnt1_b");
      pix(1, 160, 10, 2, 0, 0);
      check("clip_x_plot", 32'(bus.vga_plot), 0);
      check("clip_x_hold", 32'(bus.vga_x), 159);
      pix(1, 20, 120, 3, 0, 0);
      check("clip_y_plot", 32'(bus.vga_plot), 0);
      check("clip_y_hold", 32'(bus.vga_y), 119);
      pix(1, 5, 5, 1, 1, 1);
      wait_done("done_b");
      check("queue_b", exp_q.size(), 0);
      // Empty pass with a second frame_start while busy.
      repeat (2) tick();
      done_cnt = 0;
      saw_gnt = 1'b0;
      start(3'b000);
      check("busy_c", 32'(busy), 1);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("overrun_c", 32'(overrun), 1);
      tick();
      check("done_c", 32'(frame_done), 1);
      tick();
      check("done_off_c", {frame_done, busy}, 0);
      repeat (4) tick();
      check("done_cnt_c", done_cnt, 1);
      check("no_gnt_c", 32'(saw_gnt), 0);
      check("overrun_sticky_c", 32'(overrun), 1);
      // Renderer 1 never sends src_last.
      done_cnt = 0;
      start(3'b110);
      wait_gnt(3'b010, "gnt1_d");
      n = 0;
      while (bus.gnt == 3'b010 && n < 40) begin
         @(negedge clk);
         n++;
      end
`ifdef RENDER_WATCHDOG_EN
      check("wd_len_d", n, 16);
      check("wd_flags_d", 32'(timeout_flags), 32'b010);
`else
      check("hold_len_d", n, 40);
      check("hold_gnt_d", 32'(bus.gnt), 32'b010);
      check("no_flags_d", 32'(timeout_flags), 0);
      pix(1, 30, 31, 2, 1, 1);
`endif
      wait_gnt(3'b100, "gnt2_d");
      pix(2, 60, 61, 6, 1, 1);
      wait_done("done_d");
      check("queue_d", exp_q.size(), 0);
      // Asynchronous reset in the middle of a grant.
      repeat (2) tick();
      start(3'b010);
      wait_gnt(3'b010, "gnt1_e");
      pix(1, 40, 41, 5, 0, 1);
      check("pre_reset_plot", 32'(bus.vga_plot), 1);
      #2 reset = 1'b1;
      #1 check("async_reset", {bus.gnt, bus.vga_plot, busy, frame_done, overrun, timeout_flags}, 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      tick();
      done_cnt = 0;
      start(3'b001);
      wait_gnt(3'b001, "gnt0_e");
      pix(0, 7, 8, 3, 1, 1);
      wait_done("done_e");
      repeat (2) tick();
      check("done_cnt_e", done_cnt, 1);
      check("queue_e", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_plot_scheduler.md
Name: frame_plot_scheduler

Overview:
- Time-shares the single vga_adapter pixel-write port (x, y, colour, plot) between several renderers: runner/bird column, pipe columns and background clear.
- On each frame_start pulse it grants the port to each requesting renderer in turn, in fixed index order.
- It forwards the granted renderer's pixels and signals frame_done once all renderers have finished.
- It sits between the per-frame renderers and vga_adapter and removes the multiple-driver conflict on x/y/colour.

Parameters:
- NUM_SRC, 3, number of renderers; index 0 has the highest priority.
- H_RES, 160, horizontal resolution. Pixels with x >= H_RES are clipped.
- V_RES, 120, vertical resolution. Pixels with y >= V_RES are clipped.
- TIMEOUT, 16384, maximum number of cycles a single grant may last (used only with the watchdog feature).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse that starts a render pass
- req  in  NUM_SRC  renderer i has pixels to draw in this frame
- src_valid  in  NUM_SRC  renderer i is presenting a pixel
- src_last  in  NUM_SRC  marks the final pixel of renderer i; only meaningful when src_valid[i] is high
- src_x  in  8*NUM_SRC  packed x coordinates; renderer i uses [8i+7:8i]
- src_y  in  7*NUM_SRC  packed y coordinates; renderer i uses [7i+6:7i]
- src_colour  in  3*NUM_SRC  packed colours; renderer i uses [3i+2:3i]
- gnt  out  NUM_SRC  registered one-hot grant
- vga_x  out  8  pixel x coordinate to vga_adapter
- vga_y  out  7  pixel y coordinate to vga_adapter
- vga_colour  out  3  pixel colour to vga_adapter
- vga_plot  out  1  pixel write strobe to vga_adapter
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse at the end of a pass
- overrun  out  1  sticky; frame_start arrived while busy
- timeout_flags  out  NUM_SRC  sticky per-renderer watchdog error

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset is high, every output is 0, the FSM is in IDLE, and the pending mask and watchdog counter are cleared. Asserting reset mid-pass aborts the pass immediately; gnt and vga_plot drop without waiting for a clock edge.
- IDLE state:
  - On frame_start, latch req into the pending mask and go to SCAN.
  - If req is all zeros, still go through SCAN and DONE, so frame_done always follows frame_start.
- SCAN state (one cycle):
  - Select the lowest set bit of pending, set gnt to that one-hot value, and go to GRANT.
  - If pending is zero, go to DONE.
  - Timing: frame_start at edge N gives busy at N+1 and gnt at N+2.
- GRANT state:
  - On each edge where gnt[i] and src_valid[i] are both high, register renderer i's x, y and colour into vga_x, vga_y and vga_colour.
  - Set vga_plot=1 on that same edge unless x >= H_RES or y >= V_RES (clip); a clipped pixel gives vga_plot=0 and vga_x/y/colour hold their previous values.
  - Latency from the accepted valid to the vga outputs is one cycle. Throughput is one pixel per cycle.
  - src_valid from non-granted renderers is ignored.
  - src_valid&src_last on the granted renderer: that pixel is still forwarded. Clear pending[i], set gnt to 0 on the same edge, and go to SCAN. The next renderer is granted two edges later.
  - A req deasserted mid-grant has no effect. Only src_last (or the watchdog) releases the grant.
- DONE state: frame_done=1 for exactly one cycle, then go to IDLE; busy falls on the same edge.
- vga_plot defaults to 0 in every cycle where no pixel was accepted.
- overrun: frame_start while busy sets overrun, which stays set until reset. The pulse is otherwise ignored; the current pass continues unaffected. A frame_start coinciding with the DONE cycle counts as busy.
- Width rules: coordinate comparisons are unsigned. No arithmetic is applied to pixel data.

Optional Feature:
- Macro: RENDER_WATCHDOG_EN.
- Defined:
  - A 14-bit counter clears on entry to GRANT and increments every GRANT cycle.
  - When the counter reaches TIMEOUT-1 without src_last, force a release exactly as for src_last, except no pixel is forwarded in that cycle, and set timeout_flags[i]. That flag stays set until reset.
  - A src_last arriving in the same cycle as the timeout wins: the pixel is forwarded and no flag is set.
- Undefined: no counter is built, timeout_flags is tied to 0, and a grant lasts until src_last.

Test Plan:
- Reset: assert reset asynchronously mid-GRANT -> gnt, vga_plot, busy, frame_done and overrun all read 0 before the next clk edge; a following frame_start runs a normal pass.
- Two renderers: req=3'b101, frame_start; renderer 0 sends 3 pixels, renderer 2 sends 2 -> gnt=001 then 100, vga_plot high for 5 cycles with matching coordinates in order, renderer 1 never granted, frame_done once.
- Last and clip: renderer 0 presents last pixel (x=159,y=119) then is released; a later pixel at (x=160,y=10) -> first gives vga_plot=1 at (159,119), second gives vga_plot=0 with vga_x still 159.
- Empty and overrun: frame_start with req=0 -> frame_done 3 edges later, gnt never set; a second frame_start while busy -> overrun=1 stays set, only one frame_done.
- Watchdog, TIMEOUT=16 with RENDER_WATCHDOG_EN: renderer 1 never sends src_last -> gnt[1] drops after 16 cycles, timeout_flags=3'b010, renderer 2 granted next. Without the macro, renderer 1 keeps the grant indefinitely.
- Grant filtering: renderer 1 holds src_valid high while renderer 0 is granted -> renderer 1's pixels never reach vga_x/vga_y.
